// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor
// Computes x - y on 8-bit unsigned operands with one 4-bit subtract slice
// that is reused for the low and then the high nibble.
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-high reset
//   x, y  - minuend / subtrahend, captured when a start is accepted
//   start - request strobe, accepted only while idle
//   busy  - high while an operation is in progress (decoded from state)
//   done  - one-cycle pulse, r and z hold the new result
//   r     - {borrow, difference[7:0]}
//   z     - high when difference[7:0] is zero
module nibble_serial_subtractor (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [8:0] r,
    output logic       z
);

    localparam int unsigned OP_W  = 8;
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [OP_W-1:0]   xr, xr_d;
    logic [OP_W-1:0]   yr, yr_d;
    logic [NIB_W-1:0]  lo_q, lo_d;
    logic              bq, bq_d;
    logic [OP_W:0]     r_d;
    logic              z_d;
    logic              done_d;

    // Shared subtract slice: operands selected by which nibble is in flight
    logic [NIB_W-1:0]  slice_a;
    logic [NIB_W-1:0]  slice_b;
    logic              slice_bin;
    logic [NIB_W:0]    slice_res;
    logic [NIB_W-1:0]  slice_diff;
    logic              slice_bout;

    always_comb begin
        slice_a   = (state == HI) ? xr[OP_W-1:NIB_W] : xr[NIB_W-1:0];
        slice_b   = (state == HI) ? yr[OP_W-1:NIB_W] : yr[NIB_W-1:0];
        slice_bin = (state == HI) ? bq : 1'b0;
        // Extra MSB of the 5-bit difference is the borrow-out
        slice_res  = {1'b0, slice_a} - {1'b0, slice_b} - (NIB_W+1)'(slice_bin);
        slice_diff = slice_res[NIB_W-1:0];
        slice_bout = slice_res[NIB_W];
    end

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state;
        xr_d    = xr;
        yr_d    = yr;
        lo_d    = lo_q;
        bq_d    = bq;
        r_d     = r;
        z_d     = z;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    xr_d    = x;
                    yr_d    = y;
                    state_d = LO;
                end
            end
            LO: begin
                lo_d    = slice_diff;
                bq_d    = slice_bout;
                state_d = HI;
            end
            HI: begin
                r_d     = {slice_bout, slice_diff, lo_q};
                z_d     = ({slice_diff, lo_q} == OP_W'(0));
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xr   <= '0;
            yr   <= '0;
            lo_q <= '0;
            bq   <= 1'b0;
            r    <= '0;
            z    <= 1'b0;
            done <= 1'b0;
        end else begin
            xr   <= xr_d;
            yr   <= yr_d;
            lo_q <= lo_d;
            bq   <= bq_d;
            r    <= r_d;
            z    <= z_d;
            done <= done_d;
        end
    end

endmodule
